// File: rtl/run_monitor_pkg.sv
// Shared types and defaults for the run monitor: FSM states, parameter
// defaults and the all-ones "not found" sentinel.
package run_monitor_pkg;

    localparam int unsigned DEF_DATA_W     = 32;
    localparam int unsigned DEF_ADDR_W     = 5;
    localparam int unsigned DEF_NUM_CH     = 4;
    localparam int unsigned DEF_RST_CYCLES = 2;
    localparam int unsigned DEF_TIMEOUT    = 200;

    localparam logic [DEF_DATA_W-1:0] NOT_FOUND = '1;

    typedef enum logic [2:0] {
        IDLE,
        HOLD,
        RUN,
        CHECK,
        FINISHED
    } state_e;

endpackage

// File: rtl/monitor_channel.sv
// One watched-register channel: holds its configuration and a shadow of the
// last value written to the watched register during a run.
module monitor_channel
    import run_monitor_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned ADDR_W = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              cap_en,
    input  logic              cfg_we,
    input  logic [ADDR_W-1:0] cfg_reg,
    input  logic [DATA_W-1:0] cfg_val,
    input  logic              cfg_en,
    input  logic              rf_we,
    input  logic [ADDR_W-1:0] rf_waddr,
    input  logic [DATA_W-1:0] rf_wdata,
    output logic              mismatch_c,
    output logic              not_found_c
);

    logic              en_q,     en_d;
    logic [ADDR_W-1:0] reg_q,    reg_d;
    logic [DATA_W-1:0] val_q,    val_d;
    logic [DATA_W-1:0] shadow_q, shadow_d;

    // Config load and shadow capture; register 0 is hard-wired and never tracked.
    always_comb begin
        en_d     = en_q;
        reg_d    = reg_q;
        val_d    = val_q;
        shadow_d = shadow_q;
        if (cfg_we) begin
            en_d  = cfg_en;
            reg_d = cfg_reg;
            val_d = cfg_val;
        end
        if (clr) begin
            shadow_d = '0;
        end else if (cap_en && rf_we && en_q && (rf_waddr == reg_q) && (rf_waddr != '0)) begin
            shadow_d = rf_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            en_q     <= 1'b0;
            reg_q    <= '0;
            val_q    <= '0;
            shadow_q <= '0;
        end else begin
            en_q     <= en_d;
            reg_q    <= reg_d;
            val_q    <= val_d;
            shadow_q <= shadow_d;
        end
    end

    assign mismatch_c  = en_q && (shadow_q != val_q);
    assign not_found_c = en_q && (shadow_q == DATA_W'(NOT_FOUND));

endmodule

// File: rtl/run_monitor.sv
// Test-run supervisor: holds the CPU in reset, times a run, snoops register
// writes into per-channel shadows and reports a pass/fail/timeout verdict.
module run_monitor
    import run_monitor_pkg::*;
#(
    parameter int unsigned DATA_W     = DEF_DATA_W,
    parameter int unsigned ADDR_W     = DEF_ADDR_W,
    parameter int unsigned NUM_CH     = DEF_NUM_CH,
    parameter int unsigned RST_CYCLES = DEF_RST_CYCLES,
    parameter int unsigned TIMEOUT    = DEF_TIMEOUT
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic                      halt,
    input  logic                      rf_we,
    input  logic [ADDR_W-1:0]         rf_waddr,
    input  logic [DATA_W-1:0]         rf_wdata,
    input  logic                      cfg_we,
    input  logic [$clog2(NUM_CH)-1:0] cfg_ch,
    input  logic [ADDR_W-1:0]         cfg_reg,
    input  logic [DATA_W-1:0]         cfg_val,
    input  logic                      cfg_en,
    output logic                      cpu_rst,
    output logic                      done,
    output logic                      pass,
    output logic                      timeout,
    output logic [$clog2(NUM_CH)-1:0] fail_idx,
    output logic [NUM_CH-1:0]         not_found,
    output logic [31:0]               cycle_count
);

    localparam int unsigned CH_W   = $clog2(NUM_CH);
    localparam int unsigned HOLD_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

    state_e            state_q,    state_d;
    logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
    logic [31:0]       count_q,    count_d;
    logic              pass_q,     pass_d;
    logic              timeout_q,  timeout_d;
    logic [CH_W-1:0]   fail_idx_q, fail_idx_d;
    logic              done_q,     done_d;
    logic              cpu_rst_q,  cpu_rst_d;

    logic              start_ok_c;
    logic              cfg_ok_c;
    logic              run_c;
    logic [NUM_CH-1:0] mismatch_c;
    logic [NUM_CH-1:0] not_found_c;
    logic [CH_W-1:0]   low_idx_c;

    assign run_c = (state_q == RUN);

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        monitor_channel #(
            .DATA_W (DATA_W),
            .ADDR_W (ADDR_W)
        ) u_ch (
            .clk         (clk),
            .rst         (rst),
            .clr         (start_ok_c),
            .cap_en      (run_c),
            .cfg_we      (cfg_ok_c && cfg_we && (cfg_ch == CH_W'(g))),
            .cfg_reg     (cfg_reg),
            .cfg_val     (cfg_val),
            .cfg_en      (cfg_en),
            .rf_we       (rf_we),
            .rf_waddr    (rf_waddr),
            .rf_wdata    (rf_wdata),
            .mismatch_c  (mismatch_c[g]),
            .not_found_c (not_found_c[g])
        );
    end

    // Lowest-numbered mismatching channel wins.
    always_comb begin
        low_idx_c = '0;
        for (int i = int'(NUM_CH) - 1; i >= 0; i--) begin
            if (mismatch_c[i]) begin
                low_idx_c = CH_W'(i);
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        hold_cnt_d = hold_cnt_q;
        count_d    = count_q;
        pass_d     = pass_q;
        timeout_d  = timeout_q;
        fail_idx_d = fail_idx_q;
        start_ok_c = 1'b0;
        cfg_ok_c   = 1'b0;
        unique case (state_q)
            IDLE, FINISHED: begin
                cfg_ok_c = 1'b1;
                if (start) begin
                    start_ok_c = 1'b1;
                    state_d    = (RST_CYCLES == 0) ? RUN : HOLD;
                    hold_cnt_d = '0;
                    count_d    = '0;
                    pass_d     = 1'b0;
                    timeout_d  = 1'b0;
                    fail_idx_d = '0;
                end
            end
            HOLD: begin
                if (hold_cnt_q == HOLD_W'(RST_CYCLES - 1)) begin
                    state_d = RUN;
                end else begin
                    hold_cnt_d = hold_cnt_q + HOLD_W'(1);
                end
            end
            RUN: begin
                if (count_q != '1) begin
                    count_d = count_q + 32'd1;
                end
                // A halt in the timeout cycle still earns a real verdict.
                if (halt) begin
                    state_d = CHECK;
                end else if (count_d >= 32'(TIMEOUT)) begin
                    state_d   = FINISHED;
                    timeout_d = 1'b1;
                    pass_d    = 1'b0;
                end
            end
            CHECK: begin
                pass_d     = ~|mismatch_c;
                fail_idx_d = low_idx_c;
                state_d    = FINISHED;
            end
            default: state_d = IDLE;
        endcase
        done_d    = (state_d == FINISHED);
        cpu_rst_d = (state_d == IDLE) || (state_d == HOLD);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            hold_cnt_q <= '0;
            count_q    <= '0;
            pass_q     <= 1'b0;
            timeout_q  <= 1'b0;
            fail_idx_q <= '0;
            done_q     <= 1'b0;
            cpu_rst_q  <= 1'b1;
        end else begin
            state_q    <= state_d;
            hold_cnt_q <= hold_cnt_d;
            count_q    <= count_d;
            pass_q     <= pass_d;
            timeout_q  <= timeout_d;
            fail_idx_q <= fail_idx_d;
            done_q     <= done_d;
            cpu_rst_q  <= cpu_rst_d;
        end
    end

    assign cpu_rst     = cpu_rst_q;
    assign done        = done_q;
    assign pass        = pass_q;
    assign timeout     = timeout_q;
    assign fail_idx    = fail_idx_q;
    assign not_found   = not_found_c;
    assign cycle_count = count_q;

endmodule

// File: tb/tb_run_monitor.sv
// Bench for run_monitor: directed vector table, hand-written corner sequences
// and randomized runs checked against a per-run verdict model.
module tb_run_monitor;

    localparam int DATA_W     = 32;
    localparam int ADDR_W     = 5;
    localparam int NUM_CH     = 4;
    localparam int CH_W       = 2;
    localparam int RST_CYCLES = 2;
    localparam int TIMEOUT    = 50;
    localparam int MAXC       = 64;

    logic                clk = 1'b0;
    logic                rst, start, halt, rf_we, cfg_we, cfg_en;
    logic [ADDR_W-1:0]   rf_waddr, cfg_reg;
    logic [DATA_W-1:0]   rf_wdata, cfg_val;
    logic [CH_W-1:0]     cfg_ch, fail_idx;
    logic                cpu_rst, done, pass, timeout;
    logic [NUM_CH-1:0]   not_found;
    logic [31:0]         cycle_count;

    always #5 clk = ~clk;

    run_monitor #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_CH(NUM_CH),
        .RST_CYCLES(RST_CYCLES), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .halt(halt),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_reg(cfg_reg), .cfg_val(cfg_val), .cfg_en(cfg_en),
        .cpu_rst(cpu_rst), .done(done), .pass(pass), .timeout(timeout),
        .fail_idx(fail_idx), .not_found(not_found), .cycle_count(cycle_count)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Model view of channel configuration and per-run write schedule.
    bit          m_en  [NUM_CH];
    int          m_reg [NUM_CH];
    logic [31:0] m_val [NUM_CH];
    bit          wr_we   [MAXC];
    int          wr_addr [MAXC];
    logic [31:0] wr_data [MAXC];
    int          mid_cfg_cyc = 0;

    typedef struct {
        int ch_a; int reg_a; logic [31:0] val_a;
        int ch_b; int reg_b; logic [31:0] val_b;
        int wc1;  int wa1;   logic [31:0] wd1;
        int wc2;  int wa2;   logic [31:0] wd2;
        int halt;
        logic pass; logic tmo; int fi; logic [3:0] nf; int cnt;
    } vec_t;

    vec_t vecs[11];

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_clear();
        for (int i = 0; i < NUM_CH; i++) begin
            m_en[i] = 0; m_reg[i] = 0; m_val[i] = '0;
        end
    endtask

    task automatic clear_writes();
        for (int c = 0; c < MAXC; c++) begin
            wr_we[c] = 0; wr_addr[c] = 0; wr_data[c] = '0;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        model_clear();
    endtask

    task automatic cfg_write(input int ch, input int rg, input logic [31:0] val, input bit en);
        cfg_we  = 1'b1;
        cfg_ch  = CH_W'(ch);
        cfg_reg = ADDR_W'(rg);
        cfg_val = val;
        cfg_en  = en;
        tick();
        cfg_we  = 1'b0;
        m_en[ch] = en; m_reg[ch] = rg; m_val[ch] = val;
    endtask

    task automatic disable_all();
        for (int i = 0; i < NUM_CH; i++) cfg_write(i, 0, 32'h0, 1'b0);
    endtask

    // Verdict computed from the rules: last qualifying write per channel up to
    // the final RUN cycle, then compare against expectations.
    function automatic void model(input int halt_cyc, output logic e_pass, output logic e_to,
                                  output int e_fi, output logic [3:0] e_nf, output int e_cnt);
        logic [31:0] sh [NUM_CH];
        bit halted;
        int last;
        halted = (halt_cyc >= 1) && (halt_cyc <= TIMEOUT);
        last   = halted ? halt_cyc : TIMEOUT;
        for (int i = 0; i < NUM_CH; i++) sh[i] = '0;
        for (int c = 1; c <= last; c++)
            if (wr_we[c] && wr_addr[c] != 0)
                for (int i = 0; i < NUM_CH; i++)
                    if (m_en[i] && m_reg[i] == wr_addr[c]) sh[i] = wr_data[c];
        e_cnt = last; e_to = !halted; e_pass = halted; e_fi = 0; e_nf = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (m_en[i] && sh[i] == 32'hFFFF_FFFF) e_nf[i] = 1'b1;
            if (halted && m_en[i] && sh[i] != m_val[i]) begin
                e_pass = 1'b0;
                e_fi   = i;
            end
        end
    endfunction

    task automatic run_check(input string name, input int halt_cyc, input logic e_pass,
                             input logic e_to, input int e_fi, input logic [3:0] e_nf, input int e_cnt);
        bit fin;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < RST_CYCLES; i++) begin
            check({name, "/cpu_rst_hold"}, cpu_rst, 1);
            tick();
        end
        check({name, "/cpu_rst_run"}, cpu_rst, 0);
        check({name, "/count_start"}, cycle_count, 0);
        fin = 0;
        for (int k = 1; k <= TIMEOUT && !fin; k++) begin
            rf_we    = wr_we[k];
            rf_waddr = ADDR_W'(wr_addr[k]);
            rf_wdata = wr_data[k];
            halt     = (k == halt_cyc);
            if (k == mid_cfg_cyc) begin
                cfg_we = 1'b1; cfg_ch = '0; cfg_reg = ADDR_W'(19); cfg_val = 32'd6; cfg_en = 1'b1;
                start  = 1'b1;
            end
            tick();
            rf_we = 1'b0; halt = 1'b0; cfg_we = 1'b0; start = 1'b0;
            if (k == halt_cyc) fin = 1;
        end
        if (fin) begin
            check({name, "/done_in_check"}, done, 0);
            tick();
        end
        check({name, "/done"},      done, 1);
        check({name, "/pass"},      pass, e_pass);
        check({name, "/timeout"},   timeout, e_to);
        check({name, "/fail_idx"},  fail_idx, e_fi);
        check({name, "/not_found"}, not_found, e_nf);
        check({name, "/count"},     cycle_count, e_cnt);
    endtask

    function automatic logic [31:0] pick_val();
        int r;
        r = $urandom_range(0, 3);
        return (r == 3) ? 32'hFFFF_FFFF : 32'(r);
    endfunction

    initial begin
        logic e_pass, e_to;
        int e_fi, e_cnt;
        logic [3:0] e_nf;

        rst = 1'b0; start = 1'b0; halt = 1'b0; rf_we = 1'b0; rf_waddr = '0; rf_wdata = '0;
        cfg_we = 1'b0; cfg_ch = '0; cfg_reg = '0; cfg_val = '0; cfg_en = 1'b0;

        //          ch_a reg_a val_a          ch_b reg_b val_b  wc1 wa1 wd1            wc2 wa2 wd2            halt pass tmo fi nf       cnt
        vecs[0]  = '{0, 19, 32'd5,           -1, 0, 32'd0,    10, 19, 32'd5,          0, 0, 32'd0,           20, 1, 0, 0, 4'b0000, 20};
        vecs[1]  = '{0, 19, 32'd5,            2, 7, 32'd3,     3, 19, 32'd5,          6, 7, 32'd4,           12, 0, 0, 2, 4'b0000, 12};
        vecs[2]  = '{1, 19, 32'hFFFF_FFFF,   -1, 0, 32'd0,     4, 19, 32'hFFFF_FFFF,  0, 0, 32'd0,            9, 1, 0, 0, 4'b0010,  9};
        vecs[3]  = '{0, 19, 32'd5,           -1, 0, 32'd0,     2, 19, 32'd5,          0, 0, 32'd0,            0, 0, 1, 0, 4'b0000, 50};
        vecs[4]  = '{0, 19, 32'd5,           -1, 0, 32'd0,     2, 19, 32'd5,          0, 0, 32'd0,           50, 1, 0, 0, 4'b0000, 50};
        vecs[5]  = '{3,  0, 32'd7,           -1, 0, 32'd0,     2,  0, 32'd7,          0, 0, 32'd0,            5, 0, 0, 3, 4'b0000,  5};
        vecs[6]  = '{-1, 0, 32'd0,           -1, 0, 32'd0,     0,  0, 32'd0,          0, 0, 32'd0,            1, 1, 0, 0, 4'b0000,  1};
        vecs[7]  = '{0,  5, 32'd9,            1, 5, 32'd9,     2,  5, 32'd9,          0, 0, 32'd0,            4, 1, 0, 0, 4'b0000,  4};
        vecs[8]  = '{0,  3, 32'd1,           -1, 0, 32'd0,     2,  3, 32'hFFFF_FFFF,  5, 3, 32'd1,            6, 1, 0, 0, 4'b0000,  6};
        vecs[9]  = '{0,  3, 32'd1,           -1, 0, 32'd0,     2,  3, 32'd1,          5, 3, 32'hFFFF_FFFF,    6, 0, 0, 0, 4'b0001,  6};
        vecs[10] = '{0,  4, 32'd6,           -1, 0, 32'd0,     8,  4, 32'd6,          0, 0, 32'd0,            8, 1, 0, 0, 4'b0000,  8};

        do_reset();
        check("reset/cpu_rst",   cpu_rst, 1);
        check("reset/done",      done, 0);
        check("reset/pass",      pass, 0);
        check("reset/timeout",   timeout, 0);
        check("reset/fail_idx",  fail_idx, 0);
        check("reset/not_found", not_found, 0);
        check("reset/count",     cycle_count, 0);

        for (int v = 0; v < 11; v++) begin
            disable_all();
            if (vecs[v].ch_a >= 0) cfg_write(vecs[v].ch_a, vecs[v].reg_a, vecs[v].val_a, 1'b1);
            if (vecs[v].ch_b >= 0) cfg_write(vecs[v].ch_b, vecs[v].reg_b, vecs[v].val_b, 1'b1);
            clear_writes();
            if (vecs[v].wc1 > 0) begin
                wr_we[vecs[v].wc1] = 1; wr_addr[vecs[v].wc1] = vecs[v].wa1; wr_data[vecs[v].wc1] = vecs[v].wd1;
            end
            if (vecs[v].wc2 > 0) begin
                wr_we[vecs[v].wc2] = 1; wr_addr[vecs[v].wc2] = vecs[v].wa2; wr_data[vecs[v].wc2] = vecs[v].wd2;
            end
            run_check($sformatf("vec%0d", v), vecs[v].halt, vecs[v].pass, vecs[v].tmo,
                      vecs[v].fi, vecs[v].nf, vecs[v].cnt);
        end

        // Mid-run cfg write and start pulse must both be ignored.
        disable_all();
        cfg_write(0, 19, 32'd5, 1'b1);
        clear_writes();
        wr_we[2] = 1; wr_addr[2] = 19; wr_data[2] = 32'd5;
        mid_cfg_cyc = 3;
        run_check("cfg_in_run", 10, 1, 0, 0, 4'b0000, 10);
        mid_cfg_cyc = 0;
        for (int i = 0; i < 3; i++) tick();
        check("hold/done",  done, 1);
        check("hold/pass",  pass, 1);
        check("hold/count", cycle_count, 10);

        // Reset in the middle of a run aborts, then a fresh run behaves normally.
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < RST_CYCLES + 5; i++) tick();
        rst = 1'b1;
        start = 1'b1;
        tick();
        rst = 1'b0;
        start = 1'b0;
        model_clear();
        check("abort/cpu_rst",   cpu_rst, 1);
        check("abort/done",      done, 0);
        check("abort/pass",      pass, 0);
        check("abort/count",     cycle_count, 0);
        tick();
        check("abort/idle_cpu_rst", cpu_rst, 1);
        cfg_write(0, 19, 32'd5, 1'b1);
        clear_writes();
        wr_we[10] = 1; wr_addr[10] = 19; wr_data[10] = 32'd5;
        run_check("after_abort", 20, 1, 0, 0, 4'b0000, 20);

        for (int r = 0; r < 30; r++) begin
            int h;
            for (int i = 0; i < NUM_CH; i++)
                cfg_write(i, $urandom_range(0, 7), pick_val(), 1'($urandom_range(0, 1)));
            clear_writes();
            for (int c = 1; c <= TIMEOUT; c++) begin
                wr_we[c]   = ($urandom_range(0, 2) == 0);
                wr_addr[c] = $urandom_range(0, 7);
                wr_data[c] = pick_val();
            end
            h = $urandom_range(1, 60);
            model(h, e_pass, e_to, e_fi, e_nf, e_cnt);
            run_check($sformatf("rand%0d", r), h, e_pass, e_to, e_fi, e_nf, e_cnt);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/run_monitor.md
RUN_MONITOR -- requirements
Module: run_monitor

Interface
REQ-001 Parameter DATA_W, default 32, width of register-file write data and expected values.
REQ-002 Parameter ADDR_W, default 5, register-file write address width.
REQ-003 Parameter NUM_CH, default 4, number of independent watched-register check channels.
REQ-004 Parameter RST_CYCLES, default 2, cycles cpu_rst is held after start.
REQ-005 Parameter TIMEOUT, default 200, maximum RUN cycles before timeout; TIMEOUT shall be at least 1.
REQ-006 Port clk  input  1  single clock; all state updates on its rising edge.
REQ-007 Port rst  input  1  reset, synchronous, active-high.
REQ-008 Port start  input  1  one-cycle pulse that launches a run.
REQ-009 Port halt  input  1  CPU reports program completion.
REQ-010 Ports rf_we (1), rf_waddr (ADDR_W), rf_wdata (DATA_W), all inputs: snooped register-file write port.
REQ-011 Ports cfg_we (1), cfg_ch ($clog2(NUM_CH)), cfg_reg (ADDR_W), cfg_val (DATA_W), cfg_en (1), all inputs: channel configuration write.
REQ-012 Port cpu_rst  output  1  reset driven to the CPU under test.
REQ-013 Ports done, pass, timeout  outputs  1 each  run verdict.
REQ-014 Port fail_idx  output  $clog2(NUM_CH)  lowest-numbered failing channel.
REQ-015 Port not_found  output  NUM_CH  per-channel flag: captured value equals all-ones (-1 sentinel).
REQ-016 Port cycle_count  output  32  RUN cycles elapsed in the current or last run.

Function
REQ-017 FSM states: IDLE, HOLD, RUN, CHECK, FINISHED.
REQ-018 IDLE/FINISHED + start -> HOLD; the counter clears; all channel shadows clear to 0.
REQ-019 HOLD drives cpu_rst=1 for exactly RST_CYCLES cycles, then -> RUN with cpu_rst=0.
REQ-020 RUN: cycle_count increments by 1 each cycle and saturates at 2^32-1.
REQ-021 RUN: rf_we=1 with rf_waddr equal to an enabled channel's cfg_reg loads rf_wdata into that channel's shadow; several channels may watch the same register; writes to address 0 are ignored.
REQ-022 RUN + halt -> CHECK; in RUN, cycle_count reaching TIMEOUT without halt -> FINISHED with timeout=1, pass=0.
REQ-023 Halt and timeout in the same cycle: halt wins.
REQ-024 CHECK lasts one cycle: pass=1 iff every enabled channel's shadow equals its cfg_val; fail_idx is the lowest mismatching enabled channel, else 0; -> FINISHED.
REQ-025 No enabled channels: pass=1 when halt is reached.
REQ-026 done=1 exactly in FINISHED; pass, timeout, fail_idx, not_found and cycle_count hold until the next start.
REQ-027 cfg_we is honoured only in IDLE or FINISHED and is ignored otherwise; start is ignored in HOLD, RUN and CHECK.
REQ-028 not_found[i] = enabled[i] and shadow[i] == all-ones, updated combinationally from the shadow.

Reset
REQ-029 rst=1 -> IDLE; cpu_rst=1, done=0, pass=0, timeout=0, fail_idx=0, not_found=0, cycle_count=0; all shadows, cfg_val and cfg_reg = 0; all channels disabled.
REQ-030 rst mid-run aborts without a verdict; rst has priority over start, halt and cfg_we.
REQ-031 cpu_rst stays 1 in IDLE, so the CPU is held in reset until a run is started.

Structure
REQ-032 Package run_monitor_pkg holds the state enum, the NOT_FOUND all-ones constant (DATA_W-sized) and the default parameter values.
REQ-033 Sub-module monitor_channel holds one channel's config, shadow, match and not-found logic; it is instantiated NUM_CH times through a generate loop.

Verification
REQ-034 Config ch0 reg19 exp 5; start; write r19=5 at RUN cycle 10; halt at 20 -> done=1, pass=1, cycle_count=20, not_found=0.
REQ-035 Config ch0 reg19 exp 5, ch2 reg7 exp 3; write r19=5, r7=4; halt -> pass=0, fail_idx=2.
REQ-036 Config ch1 reg19 exp 0xFFFFFFFF; write r19=-1; halt -> pass=1, not_found=4'b0010.
REQ-037 TIMEOUT=50, no halt -> done=1 at RUN cycle 50, timeout=1, pass=0; halt and timeout together at cycle 50 -> pass verdict, timeout=0.
REQ-038 rst at RUN cycle 5 -> IDLE, cpu_rst=1, done=0; a new start runs cleanly; cpu_rst stays high exactly RST_CYCLES cycles after start.
REQ-039 cfg_we during RUN changing ch0 exp -> ignored; verdict uses the original value.
